// File: rtl/clock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clock_pkg : shared states, field codes and BCD limits for time set  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_AMPM = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_AMPM = 2'd3;

  localparam int HOUR_MAX = 12;
  localparam int HOUR_MIN = 1;
  localparam int MIN_MAX  = 59;
  localparam int MIN_MIN  = 0;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(input int v);
    bcd2_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

  function automatic bcd2_t clamp_hour(input bcd2_t h);
    logic bad;
    bad = (h.units > 4'd9) || (h.tens > 4'd1) ||
          (h.tens == 4'd0 && h.units == 4'd0) ||
          (h.tens == 4'd1 && h.units > 4'd2);
    return bad ? to_bcd2(HOUR_MAX) : h;
  endfunction

  // Tens above 5 is also zeroed so the minute can never escape its wrap range.
  function automatic bcd2_t clamp_min(input bcd2_t m);
    bcd2_t r;
    r.tens  = (m.tens  > 4'd5) ? 4'd0 : m.tens;
    r.units = (m.units > 4'd9) ? 4'd0 : m.units;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_wrap_inc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_wrap_inc : two-digit BCD increment wrapping MAX_VAL -> MIN_VAL  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bcd_wrap_inc
  import clock_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  bcd2_t i_val,
  output bcd2_t o_val
);

  localparam bcd2_t C_MIN = to_bcd2(MIN_VAL);
  localparam bcd2_t C_MAX = to_bcd2(MAX_VAL);

  always_comb begin
    o_val = i_val;
    if (i_val == C_MAX) begin
      o_val = C_MIN;
    end else if (i_val.units == 4'd9) begin
      o_val.tens  = i_val.tens + 4'd1;
      o_val.units = 4'd0;
    end else begin
      o_val.units = i_val.units + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | time_set_ctrl : button-driven hour/minute/AM-PM editor for a clock  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  input  logic       cur_am,
  output logic [3:0] set_hour_tens,
  output logic [3:0] set_hour_units,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_units,
  output logic       set_am,
  output logic       load,
  output logic       setting,
  output logic [1:0] field
);

  localparam int             IW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          mode_prev_q, inc_prev_q;
  bcd2_t         hour_q, hour_d, min_q, min_d;
  logic          am_q, am_d;
  logic          load_q, load_d;
  logic          mode_edge, inc_edge;
  bcd2_t         hour_inc, min_inc;

  bcd_wrap_inc #(.MIN_VAL(HOUR_MIN), .MAX_VAL(HOUR_MAX)) u_hour_inc (
    .i_val (hour_q),
    .o_val (hour_inc)
  );

  bcd_wrap_inc #(.MIN_VAL(MIN_MIN), .MAX_VAL(MIN_MAX)) u_min_inc (
    .i_val (min_q),
    .o_val (min_inc)
  );

  always_comb begin
    mode_edge = btn_mode & ~mode_prev_q;
    inc_edge  = btn_inc  & ~inc_prev_q;
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    am_d      = am_q;
    load_d    = 1'b0;

    // Mode always wins over a simultaneous inc edge.
    case (state_q)
      RUN: begin
        if (mode_edge) begin
          state_d = SET_HOUR;
          hour_d  = clamp_hour({cur_hour_tens, cur_hour_units});
          min_d   = clamp_min({cur_min_tens, cur_min_units});
          am_d    = cur_am;
        end
      end
      SET_HOUR: begin
        if (mode_edge)     state_d = SET_MIN;
        else if (inc_edge) hour_d  = hour_inc;
      end
      SET_MIN: begin
        if (mode_edge)     state_d = SET_AMPM;
        else if (inc_edge) min_d   = min_inc;
      end
      SET_AMPM: begin
        if (mode_edge) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_edge) begin
          am_d = ~am_q;
        end
      end
    endcase

    if (state_q != RUN && !mode_edge && !inc_edge && idle_q == IDLE_LAST)
      state_d = RUN;

    if (state_q == RUN || mode_edge || inc_edge || state_d != state_q)
      idle_d = '0;
    else
      idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      idle_q      <= '0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      hour_q      <= to_bcd2(HOUR_MAX);
      min_q       <= to_bcd2(0);
      am_q        <= 1'b1;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      hour_q      <= hour_d;
      min_q       <= min_d;
      am_q        <= am_d;
      load_q      <= load_d;
    end
  end

  always_comb begin
    field = FIELD_NONE;
    case (state_q)
      SET_HOUR: field = FIELD_HOUR;
      SET_MIN:  field = FIELD_MIN;
      SET_AMPM: field = FIELD_AMPM;
      default:  field = FIELD_NONE;
    endcase
  end

  assign setting        = (state_q != RUN);
  assign load           = load_q;
  assign set_hour_tens  = hour_q.tens;
  assign set_hour_units = hour_q.units;
  assign set_min_tens   = min_q.tens;
  assign set_min_units  = min_q.units;
  assign set_am         = am_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_time_set_ctrl : directed self-checking bench for time_set_ctrl   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_hour_tens = 4'd0, cur_hour_units = 4'd0;
  logic [3:0] cur_min_tens = 4'd0, cur_min_units = 4'd0;
  logic       cur_am = 1'b0;
  logic [3:0] set_hour_tens, set_hour_units, set_min_tens, set_min_units;
  logic       set_am, load, setting;
  logic [1:0] field;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_mode       (btn_mode),
    .btn_inc        (btn_inc),
    .cur_hour_tens  (cur_hour_tens),
    .cur_hour_units (cur_hour_units),
    .cur_min_tens   (cur_min_tens),
    .cur_min_units  (cur_min_units),
    .cur_am         (cur_am),
    .set_hour_tens  (set_hour_tens),
    .set_hour_units (set_hour_units),
    .set_min_tens   (set_min_tens),
    .set_min_units  (set_min_units),
    .set_am         (set_am),
    .load           (load),
    .setting        (setting),
    .field          (field)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input logic [3:0] ht, input logic [3:0] hu,
                         input logic [3:0] mt, input logic [3:0] mu, input logic am);
    cur_hour_tens = ht; cur_hour_units = hu;
    cur_min_tens = mt;  cur_min_units = mu;
    cur_am = am;
  endtask

  task automatic mode_pulse();
    btn_mode = 1'b1; tick();
    btn_mode = 1'b0; tick();
  endtask

  task automatic inc_pulse();
    btn_inc = 1'b1; tick();
    btn_inc = 1'b0; tick();
  endtask

  // Compares the edited time as hex digits HHMM followed by the AM bit.
  task automatic chk_set(input string tag, input logic [15:0] hhmm, input logic am);
    chk(tag, {11'd0, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_am},
        {11'd0, hhmm, am});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    chk("rst_setting", setting, 1'b0);
    chk("rst_field", field, 2'd0);
    chk("rst_load", load, 1'b0);
    chk_set("rst_set", 16'h1200, 1'b1);
    rst = 1'b0;
    tick();

    // Capture 11:58 PM, step hour across the 12 -> 01 wrap
    set_cur(4'd1, 4'd1, 4'd5, 4'd8, 1'b0);
    mode_pulse();
    chk("cap_setting", setting, 1'b1);
    chk("cap_field", field, 2'd1);
    chk_set("cap_set", 16'h1158, 1'b0);
    inc_pulse();
    chk_set("hour_12", 16'h1258, 1'b0);
    inc_pulse();
    chk_set("hour_wrap_01", 16'h0158, 1'b0);

    mode_pulse();
    chk("min_field", field, 2'd2);
    inc_pulse();
    chk_set("min_59", 16'h0159, 1'b0);
    inc_pulse();
    chk_set("min_wrap_00", 16'h0100, 1'b0);

    mode_pulse();
    chk("ampm_field", field, 2'd3);
    inc_pulse();
    chk_set("ampm_toggle", 16'h0100, 1'b1);

    btn_mode = 1'b1; tick();
    chk("load_hi", load, 1'b1);
    chk("load_setting", setting, 1'b0);
    chk("load_field", field, 2'd0);
    chk_set("load_set", 16'h0100, 1'b1);
    btn_mode = 1'b0; tick();
    chk("load_one_cycle", load, 1'b0);

    // Simultaneous mode and inc in SET_HOUR
    set_cur(4'd0, 4'd9, 4'd0, 4'd7, 1'b1);
    mode_pulse();
    chk_set("cap_0907", 16'h0907, 1'b1);
    btn_mode = 1'b1; btn_inc = 1'b1; tick();
    chk("both_field", field, 2'd2);
    chk_set("both_hour_kept", 16'h0907, 1'b1);
    btn_mode = 1'b0; btn_inc = 1'b0; tick();
    mode_pulse();
    mode_pulse();
    chk("back_run", setting, 1'b0);
    inc_pulse();
    chk_set("inc_in_run", 16'h0907, 1'b1);

    // Idle timeout with TIMEOUT_CYCLES = 8
    set_cur(4'd0, 4'd4, 4'd2, 4'd0, 1'b0);
    btn_mode = 1'b1; tick();
    chk("to_enter", setting, 1'b1);
    btn_mode = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_setting_%0d", k), setting, (k < 8) ? 1'b1 : 1'b0);
      chk($sformatf("to_load_%0d", k), load, 1'b0);
    end
    chk_set("to_kept", 16'h0420, 1'b0);
    chk("to_field", field, 2'd0);

    // Hour clamp and held-button single edge
    set_cur(4'd0, 4'd0, 4'd3, 4'd0, 1'b1);
    mode_pulse();
    chk_set("clamp_00", 16'h1230, 1'b1);
    repeat (10) tick();
    chk("clamp_to_run", setting, 1'b0);
    set_cur(4'd1, 4'd3, 4'd4, 4'd5, 1'b0);
    mode_pulse();
    chk_set("clamp_13", 16'h1245, 1'b0);
    btn_inc = 1'b1; tick();
    chk_set("held_first", 16'h0145, 1'b0);
    repeat (5) tick();
    chk("held_still_edit", setting, 1'b1);
    chk_set("held_mid", 16'h0145, 1'b0);
    repeat (14) tick();
    chk_set("held_end", 16'h0145, 1'b0);
    btn_inc = 1'b0; tick();
    chk("held_to_run", setting, 1'b0);

    set_cur(4'd1, 4'hA, 4'hC, 4'd3, 1'b1);
    mode_pulse();
    chk_set("clamp_nonbcd", 16'h1203, 1'b1);
    repeat (10) tick();

    // Reset in the middle of an edit
    set_cur(4'd0, 4'd9, 4'd1, 4'd5, 1'b0);
    mode_pulse();
    inc_pulse();
    chk_set("pre_rst_hour", 16'h1015, 1'b0);
    mode_pulse();
    chk("pre_rst_field", field, 2'd2);
    rst = 1'b1; tick();
    chk("rst_mid_setting", setting, 1'b0);
    chk("rst_mid_field", field, 2'd0);
    chk("rst_mid_load", load, 1'b0);
    chk_set("rst_mid_set", 16'h1200, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst_load_%0d", k), load, 1'b0);
    end
    chk("post_rst_setting", setting, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
